// File: rtl/morse_decoder.sv
// morse_decoder: samples a serial Morse line at mid-unit, classifies marks and decodes letters A-H.
// Build option MORSE_DEC_TOLERANT_EN: also accept 2- and 4-unit marks as dashes.
module morse_decoder #(
  parameter int TICK_DIV = 250
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       DotDashIn,
  output logic [2:0] Letter,
  output logic       Valid,
  output logic       Error,
  output logic       Busy
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] HALF_RELOAD = DIV_W'(TICK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_RELOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
`ifdef MORSE_DEC_TOLERANT_EN
  localparam logic [2:0] RUN_LIMIT = 3'd5;
`else
  localparam logic [2:0] RUN_LIMIT = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_RECOVER
  } state_t;

  // Returns {accepted, is_dash} for a completed mark run length.
  function automatic logic [1:0] classify(input logic [2:0] run);
`ifdef MORSE_DEC_TOLERANT_EN
    case (run)
      3'd1:             classify = 2'b10;
      3'd2, 3'd3, 3'd4: classify = 2'b11;
      default:          classify = 2'b00;
    endcase
`else
    case (run)
      3'd1:    classify = 2'b10;
      3'd3:    classify = 2'b11;
      default: classify = 2'b00;
    endcase
`endif
  endfunction

  // Returns {hit, code}; elements are oldest-first from MSB down, dash = 1.
  function automatic logic [3:0] lookup(input logic [2:0] count, input logic [3:0] elem);
    case ({count, elem})
      7'b010_0001: lookup = 4'b1_000;  // A .-
      7'b100_1000: lookup = 4'b1_001;  // B -...
      7'b100_1010: lookup = 4'b1_010;  // C -.-.
      7'b011_0100: lookup = 4'b1_011;  // D -..
      7'b001_0000: lookup = 4'b1_100;  // E .
      7'b100_0010: lookup = 4'b1_101;  // F ..-.
      7'b011_0110: lookup = 4'b1_110;  // G --.
      7'b100_0000: lookup = 4'b1_111;  // H ....
      default:     lookup = 4'b0_000;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       run_q, run_d;
  logic [1:0]       gap_q, gap_d;
  logic [3:0]       elem_q, elem_d;
  logic [2:0]       count_q, count_d;
  logic [2:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic       rise;
  logic       running;
  logic       sample;
  logic [2:0] run_inc;
  logic [1:0] cls;
  logic [3:0] lut;

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      div_q    <= '0;
      run_q    <= '0;
      gap_q    <= '0;
      elem_q   <= '0;
      count_q  <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      div_q    <= div_d;
      run_q    <= run_d;
      gap_q    <= gap_d;
      elem_q   <= elem_d;
      count_q  <= count_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    sync1_d  = DotDashIn;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    rise     = sync2_q & ~prev_q;
    running  = (state_q != S_IDLE);
    sample   = running & ~rise & (div_q == '0);
    run_inc  = (run_q == 3'd7) ? run_q : run_q + 3'd1;
    cls      = classify(run_q);
    lut      = lookup(count_q, elem_q);
    state_d  = state_q;
    run_d    = run_q;
    gap_d    = gap_q;
    elem_d   = elem_q;
    count_d  = count_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    // Every rising edge re-centres sampling half a unit later.
    if (rise)
      div_d = HALF_RELOAD;
    else if (sample)
      div_d = FULL_RELOAD;
    else if (running)
      div_d = div_q - DIV_ONE;
    else
      div_d = '0;

    case (state_q)
      S_IDLE: begin
        run_d   = '0;
        gap_d   = '0;
        elem_d  = '0;
        count_d = '0;
        if (rise)
          state_d = S_MARK;
      end
      S_MARK: begin
        if (sample) begin
          if (sync2_q) begin
            run_d = run_inc;
            if (run_inc >= RUN_LIMIT) begin
              error_d = 1'b1;
              gap_d   = '0;
              state_d = S_RECOVER;
            end
          end else if (!cls[1] || count_q == 3'd4) begin
            error_d = 1'b1;
            gap_d   = 2'd1;
            state_d = S_RECOVER;
          end else begin
            elem_d  = {elem_q[2:0], cls[0]};
            count_d = count_q + 3'd1;
            gap_d   = 2'd1;
            state_d = S_SPACE;
          end
        end
      end
      S_SPACE: begin
        if (rise) begin
          run_d   = '0;
          state_d = S_MARK;
        end else if (sample && !sync2_q) begin
          if (gap_q == 2'd2) begin
            if (lut[3]) begin
              letter_d = lut[2:0];
              valid_d  = 1'b1;
            end else begin
              error_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + 2'd1;
          end
        end
      end
      S_RECOVER: begin
        // Any high sample restarts the wait for a clean letter gap.
        if (sample) begin
          if (sync2_q)
            gap_d = '0;
          else if (gap_q == 2'd2)
            state_d = S_IDLE;
          else
            gap_d = gap_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Letter = letter_q;
  assign Valid  = valid_q;
  assign Error  = error_q;
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: drives transmitter-format Morse words and compares Valid/Error/Letter
// against a pattern-string model of the letter table.
`timescale 1ns/1ps
module tb_morse_decoder;

  localparam int TD       = 20;
  localparam int LONG_GAP = 6;
  localparam int LAT      = TD * 5 / 2 + 3;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       line = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  morse_decoder #(.TICK_DIV(TD)) dut (
    .ClockIn  (clk),
    .Resetn   (rstn),
    .DotDashIn(line),
    .Letter   (letter),
    .Valid    (valid),
    .Error    (error),
    .Busy     (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int vcnt    = 0;
  int ecnt    = 0;
  int vletter = 0;
  int vcyc    = 0;
  logic [2:0] prev_letter = 3'd0;
  int wq[$];
  int gq[$];
  string table_pat[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || error)
      check("valid_error_exclusive", int'(valid & error), 0);
    if (rstn && letter != prev_letter)
      check("letter_moves_only_with_valid", int'(valid), 1);
    prev_letter <= letter;
    if (valid) begin
      vcnt    <= vcnt + 1;
      vletter <= int'(letter);
      vcyc    <= cyc;
    end
    if (error)
      ecnt <= ecnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input logic v, input int units);
    line = v;
    repeat (units * TD) @(posedge clk);
    #1;
  endtask

  task automatic pattern_to_marks(input string p);
    wq.delete();
    gq.delete();
    for (int j = 0; j < p.len(); j++) begin
      wq.push_back((p[j] == "-") ? 3 : 1);
      gq.push_back($urandom_range(1, 2));
    end
  endtask

  // Reference: each mark becomes '.', '-' or invalid by its length; the word is a letter
  // only if every mark is valid and the resulting string is in the table.
  function automatic void model_word(output bit ok, output int code, output string pat);
    bit bad;
    bad  = 1'b0;
    pat  = "";
    ok   = 1'b0;
    code = 0;
    foreach (wq[i]) begin
      if (wq[i] == 1)
        pat = {pat, "."};
`ifdef MORSE_DEC_TOLERANT_EN
      else if (wq[i] >= 2 && wq[i] <= 4)
        pat = {pat, "-"};
`else
      else if (wq[i] == 3)
        pat = {pat, "-"};
`endif
      else begin
        pat = {pat, "x"};
        bad = 1'b1;
      end
    end
    if (!bad && pat.len() <= 4) begin
      for (int k = 0; k < 8; k++) begin
        if (pat == table_pat[k]) begin
          ok   = 1'b1;
          code = k;
        end
      end
    end
  endfunction

  task automatic send_word(input string name);
    bit    ok;
    int    code;
    string pat;
    string marks;
    int    fall_cyc;
    int    lat;
    model_word(ok, code, pat);
    marks = "";
    foreach (wq[i]) marks = {marks, $sformatf("%0d", wq[i])};
    vcnt     = 0;
    ecnt     = 0;
    vletter  = -1;
    vcyc     = 0;
    fall_cyc = 0;
    foreach (wq[i]) begin
      hold(1'b1, wq[i]);
      if (i == 0)
        check({name, "_busy_in_letter"}, int'(busy), 1);
      if (i != wq.size() - 1)
        hold(1'b0, gq[i]);
    end
    fall_cyc = cyc;
    hold(1'b0, LONG_GAP);
    check({name, "_valid_count"}, vcnt, ok ? 1 : 0);
    check({name, "_error_count"}, ecnt, ok ? 0 : 1);
    if (ok) begin
      check({name, "_letter"}, vletter, code);
      lat = vcyc - fall_cyc;
      check({name, "_latency"}, (lat >= LAT - 3 && lat <= LAT + 3) ? LAT : lat, LAT);
    end
    check({name, "_busy_after_gap"}, int'(busy), 0);
    $display("tx %-8s marks=%-6s pat=%-6s exp=%s got valid=%0d err=%0d letter=%0d",
             name, marks, pat, ok ? $sformatf("letter%0d", code) : "error",
             vcnt, ecnt, vletter);
  endtask

  initial begin
    rstn = 1'b0;
    line = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      line = ~line;
      @(posedge clk);
      #1;
    end
    check("reset_letter", int'(letter), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_error", int'(error), 0);
    check("reset_busy", int'(busy), 0);
    line = 1'b0;
    rstn = 1'b1;
    hold(1'b0, 2);
    check("idle_after_release", int'(busy), 0);

    for (int k = 0; k < 8; k++) begin
      pattern_to_marks(table_pat[k]);
      send_word($sformatf("letter%0d", k));
    end

    // Reset after "-." of C: everything clears and the partial letter stays silent.
    vcnt = 0;
    ecnt = 0;
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_letter", int'(letter), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(valid), 0);
    rstn = 1'b1;
    hold(1'b0, LONG_GAP);
    check("midreset_no_valid", vcnt, 0);
    check("midreset_no_error", ecnt, 0);
    $display("tx midreset partial C cleared valid=%0d err=%0d", vcnt, ecnt);
    pattern_to_marks(".");
    send_word("post_rst");

    wq = '{2};
    gq = '{1};
    send_word("bad2");
    wq = '{2, 1};
    gq = '{1, 1};
    send_word("bad2dot");
    wq = '{2, 1, 1};
    gq = '{1, 1, 1};
    send_word("bad2dd");
    wq = '{1, 1, 1, 1, 1};
    gq = '{1, 1, 1, 1, 1};
    send_word("fivedot");

    // Overlong mark: error while still high, then held busy until a clean gap.
    vcnt = 0;
    ecnt = 0;
    hold(1'b1, 6);
    check("overlong_error", ecnt, 1);
    check("overlong_busy_held", int'(busy), 1);
    hold(1'b0, LONG_GAP);
    check("overlong_idle", int'(busy), 0);
    check("overlong_no_valid", vcnt, 0);
    $display("tx overlong 6-unit mark err=%0d valid=%0d", ecnt, vcnt);
    pattern_to_marks(".-");
    send_word("after_ovl");

    for (int w = 0; w < 30; w++) begin
      if ($urandom_range(0, 1) == 1) begin
        pattern_to_marks(table_pat[$urandom_range(0, 7)]);
      end else begin
        int n;
        int r;
        n = $urandom_range(1, 5);
        wq.delete();
        gq.delete();
        for (int j = 0; j < n; j++) begin
          r = $urandom_range(0, 9);
          wq.push_back((r < 5) ? 1 : (r < 8) ? 3 : $urandom_range(2, 5));
          gq.push_back($urandom_range(1, 2));
        end
      end
      send_word($sformatf("rand%0d", w));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
